// File: rtl/fp16_pkg.sv
// Shared constants for the binary16 pack stage: field widths, special encodings,
// FSM state codes and flag bit positions.
package fp16_pkg;

  localparam int EXP_W     = 5;
  localparam int MANT_W    = 10;
  localparam int GRS_W     = 3;
  localparam int BIAS      = 15;
  localparam int EXP_MAX   = (1 << EXP_W) - 1;
  localparam int IN_EXP_W  = EXP_W + 2;
  localparam int IN_MANT_W = MANT_W + GRS_W + 1;
  localparam int WORD_W    = 1 + EXP_W + MANT_W;

  localparam logic [WORD_W-1:0] QNAN = 16'h7E00;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational denormalize shift, sticky collection and round-to-nearest-even
// for a finite non-zero operand, including overflow to infinity.
module fp_round_rne
  import fp16_pkg::*;
(
  input  logic                 sign_i,
  input  logic [IN_EXP_W-1:0]  exp_i,
  input  logic [IN_MANT_W-1:0] mant_i,
  output logic [WORD_W-1:0]    data_o,
  output logic [2:0]           flags_o
);

  localparam int SHIFT_CAP = IN_MANT_W + 1;
  localparam int XW        = IN_EXP_W + 1;
  localparam int EXT_W     = IN_MANT_W + SHIFT_CAP;

  localparam logic signed [XW-1:0] ONE_X     = XW'(1);
  localparam logic signed [XW-1:0] CAP_X     = XW'(SHIFT_CAP);
  localparam logic signed [XW-1:0] EXP_MAX_X = XW'(EXP_MAX);

  logic signed [XW-1:0]  exp_x;
  logic signed [XW-1:0]  shift_full;
  logic        [XW-1:0]  shift_amt;
  logic                  subnormal;
  logic [EXT_W-1:0]      ext;
  logic [IN_MANT_W-1:0]  shifted;
  logic                  sticky_out;
  logic [MANT_W:0]       sig;
  logic                  g, r, s;
  logic                  inexact;
  logic                  round_up;
  logic [MANT_W+1:0]     sig_rnd;
  logic signed [XW-1:0]  exp_rnd;
  logic [MANT_W-1:0]     frac_rnd;

  // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    exp_x      = {exp_i[IN_EXP_W-1], exp_i};
    subnormal  = (exp_x <= 0);
    shift_full = ONE_X - exp_x;
    shift_amt  = '0;
    if (subnormal) begin
      shift_amt = (shift_full > CAP_X) ? CAP_X : shift_full;
    end

    // The extension is wide enough that no bit falls off even at the capped shift.
    ext        = {mant_i, {SHIFT_CAP{1'b0}}} >> shift_amt;
    shifted    = ext[EXT_W-1 -: IN_MANT_W];
    sticky_out = |ext[SHIFT_CAP-1:0];

    sig      = shifted[IN_MANT_W-1 -: MANT_W+1];
    g        = shifted[2];
    r        = shifted[1];
    s        = shifted[0] | sticky_out;
    inexact  = g | r | s;
    round_up = g & (r | s | sig[0]);
    sig_rnd  = {1'b0, sig} + {{(MANT_W+1){1'b0}}, round_up};

    if (subnormal) begin
      // A subnormal that rounds into the hidden bit becomes the smallest normal.
      exp_rnd  = $signed({{(XW-1){1'b0}}, sig_rnd[MANT_W]});
      frac_rnd = sig_rnd[MANT_W-1:0];
    end else begin
      exp_rnd  = exp_x + $signed({{(XW-1){1'b0}}, sig_rnd[MANT_W+1]});
      frac_rnd = sig_rnd[MANT_W+1] ? sig_rnd[MANT_W:1] : sig_rnd[MANT_W-1:0];
    end

    data_o           = {sign_i, exp_rnd[EXP_W-1:0], frac_rnd};
    flags_o          = '0;
    flags_o[FLAG_NX] = inexact;
    flags_o[FLAG_UF] = subnormal & inexact;

    if (exp_rnd >= EXP_MAX_X) begin
      data_o           = {sign_i, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      flags_o          = '0;
      flags_o[FLAG_OF] = 1'b1;
      flags_o[FLAG_NX] = 1'b1;
    end
  end

endmodule

// File: rtl/store.sv
// Tail of the FP datapath: captures unpacked fields, rounds them to binary16 and
// holds the packed word under valid/ready backpressure.
module store
  import fp16_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [IN_EXP_W-1:0]  in_exp,
  input  logic [IN_MANT_W-1:0] in_mant,
  input  logic                 in_nan,
  input  logic                 in_inf,
  output logic [WORD_W-1:0]    out_data,
  output logic [2:0]           out_flags,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [1:0]           state_q, state_d;
  logic                 sign_q, nan_q, inf_q;
  logic [IN_EXP_W-1:0]  exp_q;
  logic [IN_MANT_W-1:0] mant_q;
  logic [WORD_W-1:0]    data_q, res_data, rnd_data;
  logic [2:0]           flags_q, res_flags, rnd_flags;

  fp_round_rne u_round (
    .sign_i  (sign_q),
    .exp_i   (exp_q),
    .mant_i  (mant_q),
    .data_o  (rnd_data),
    .flags_o (rnd_flags)
  );

  always_comb begin
    res_data  = rnd_data;
    res_flags = rnd_flags;
    if (nan_q) begin
      res_data  = QNAN;
      res_flags = '0;
    end else if (inf_q) begin
      res_data  = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      res_flags = '0;
    end else if (mant_q == '0) begin
      res_data  = {sign_q, {(WORD_W-1){1'b0}}};
      res_flags = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_ROUND;
      ST_ROUND: state_d = ST_OUT;
      ST_OUT:   if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ROUND) begin
        data_q  <= res_data;
        flags_q <= res_flags;
      end
    end
  end

  // NOTE: capture registers carry no reset; they are only read in ROUND, which always follows a capture.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && in_valid) begin
      sign_q <= in_sign;
      exp_q  <= in_exp;
      mant_q <= in_mant;
      nan_q  <= in_nan;
      inf_q  <= in_inf;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = data_q;
  assign out_flags = flags_q;

endmodule
